sequence_driver: RTL

- Initiator-side controller for the sequence generator's load/done/clear control protocol.
- Accepts one request at a time on a valid/ready command interface.
- Drives the generator's mode, load, order and data_in pins, waits for done, overflow or error (with a timeout), issues clear when needed, and returns the result plus a status code on a valid/ready response interface.
- Sits between a testbench or CPU-side command source and the generator.

---
 rtl/sequence_driver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sequence_driver.sv
`default_nettype none
// ============================================================================
// Module   : sequence_driver
// Purpose  : Initiator-side load/done/clear controller for the sequence
//            generator, with valid/ready command and response interfaces.
// Revision : 1.0 - initial release
// ============================================================================
module sequence_driver #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LOAD_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [15:0] req_order,
    input  logic [63:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        fibonacci,
    output logic        triangle,
    output logic        load,
    output logic        clear,
    output logic [15:0] order,
    output logic [63:0] data_in,
    input  logic        done,
    input  logic [63:0] data_out,
    input  logic        overflow,
    input  logic        error,
    output logic        spurious
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOAD_CYCLES + 1);
    localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] C_LOAD_LAST = LW'(LOAD_CYCLES - 1);

    localparam logic [1:0] C_ST_OK       = 2'b00;
    localparam logic [1:0] C_ST_OVERFLOW = 2'b01;
    localparam logic [1:0] C_ST_ERROR    = 2'b10;
    localparam logic [1:0] C_ST_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WAIT  = 3'd2,
        S_CLEAR = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [LW-1:0]   r_load_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_mode;
    logic [15:0]     r_order;
    logic [63:0]     r_data;
    logic [63:0]     r_rsp_data;
    logic [1:0]      r_rsp_status;
    logic            r_spurious;
    logic            w_to_hit;
    logic            w_drive_bus;

    assign w_to_hit = (r_to_cnt == C_TO_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (r_load_cnt == C_LOAD_LAST) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                // done outranks overflow, so a simultaneous pair needs no clear
                if (done)                                w_state_next = S_RESP;
                else if (overflow || error || w_to_hit) w_state_next = S_CLEAR;
            end
            S_CLEAR: w_state_next = S_RESP;
            S_RESP: begin
                if (rsp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_load_cnt   <= '0;
            r_to_cnt     <= '0;
            r_mode       <= 1'b0;
            r_order      <= '0;
            r_data       <= '0;
            r_rsp_data   <= '0;
            r_rsp_status <= C_ST_OK;
            r_spurious   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mode     <= req_mode;
                        r_order    <= req_order;
                        r_data     <= req_data;
                        r_load_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (r_load_cnt == C_LOAD_LAST) r_to_cnt   <= '0;
                    else                           r_load_cnt <= r_load_cnt + LW'(1);
                end
                S_WAIT: begin
                    if (done) begin
                        r_rsp_data   <= data_out;
                        r_rsp_status <= C_ST_OK;
                    end else if (overflow) begin
                        r_rsp_data   <= data_out;
                        r_rsp_status <= C_ST_OVERFLOW;
                    end else if (error) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= C_ST_ERROR;
                    end else if (w_to_hit) begin
                        r_rsp_data   <= '0;
                        r_rsp_status <= C_ST_TIMEOUT;
                    end else begin
                        r_to_cnt <= r_to_cnt + TW'(1);
                    end
                end
                default: ;
            endcase

            if ((r_state != S_WAIT) && (done || overflow || error)) r_spurious <= 1'b1;
        end
    end

    assign w_drive_bus = (r_state == S_LOAD) || (r_state == S_WAIT);

    assign req_ready  = (r_state == S_IDLE);
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
    assign load       = (r_state == S_LOAD);
    assign triangle   = (r_state == S_LOAD) && !r_mode;
    assign fibonacci  = (r_state == S_LOAD) && r_mode;
    assign clear      = (r_state == S_CLEAR);
    assign order      = w_drive_bus ? r_order : 16'd0;
    assign data_in    = w_drive_bus ? r_data  : 64'd0;
    assign spurious   = r_spurious;

endmodule
`default_nettype wire
